// File: rtl/bin2bcd_16_pkg.sv
// bin2bcd_16_pkg: shared constants and FSM encoding for the bin2bcd_16 converter.
//   STATE_W / state_t / IDLE / SHIFT : FSM encoding (legacy-compatible localparams)
//   BCD_W                            : width of one BCD digit
//   ADD3_THRESH                      : digit value at or above which add-3 applies
//   DEFAULT_DIGITS                   : digit count for the 16-bit configuration
package bin2bcd_16_pkg;

    localparam int unsigned STATE_W = 1;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t SHIFT = 1'b1;

    localparam int unsigned BCD_W          = 4;
    localparam int unsigned ADD3_THRESH    = 5;
    localparam int unsigned DEFAULT_DIGITS = 5;

endpackage

// File: rtl/bin2bcd_16_if.sv
// bin2bcd_16_if: start/busy/done handshake bundle between the display path
// (master) and the bin2bcd_16 converter (slave).
//   start  : master -> slave, request conversion of value
//   value  : master -> slave, binary operand (BIT_SZ bits)
//   busy   : slave -> master, conversion in progress
//   done   : slave -> master, one-cycle pulse, bcd just updated
//   bcd    : slave -> master, packed BCD result (4*DIGITS bits, units in [3:0])
//   blank  : slave -> master, leading-zero blanking (only with BIN2BCD_BLANK_EN)
interface bin2bcd_16_if
    import bin2bcd_16_pkg::*;
#(
    parameter int unsigned BIT_SZ = 16,
    parameter int unsigned DIGITS = DEFAULT_DIGITS
);

    logic                      start;
    logic [BIT_SZ-1:0]         value;
    logic                      busy;
    logic                      done;
    logic [BCD_W*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]         blank;

    modport master (output start, output value, input busy, input done, input bcd,
                    input blank);
    modport slave  (input start, input value, output busy, output done, output bcd,
                    output blank);
`else
    modport master (output start, output value, input busy, input done, input bcd);
    modport slave  (input start, input value, output busy, output done, output bcd);
`endif

endinterface

// File: rtl/bin2bcd_16_bcd_add3.sv
// bcd_add3: combinational double-dabble correction for one BCD digit.
//   din  : digit before the shift
//   dout : din + 3 when din >= 5, else din unchanged (no carry out)
module bcd_add3
    import bin2bcd_16_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    always_comb begin
        if (din >= BCD_W'(ADD3_THRESH)) begin
            dout = din + BCD_W'(3);
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin2bcd_16.sv
// bin2bcd_16: sequential binary-to-BCD converter (double-dabble, one bit per clock).
// A start sampled in IDLE captures value; BIT_SZ clocks later bcd is written
// whole and done pulses for one cycle. start while busy is ignored.
//   clock  : system clock, posedge
//   nreset : asynchronous active-low reset
//   bus    : bin2bcd_16_if.slave (start, value, busy, done, bcd[, blank])
// Build option: define BIN2BCD_BLANK_EN to add the registered bus.blank output
// (leading-zero flags per digit, units digit never blanked).
// The interface instance must use the same BIT_SZ/DIGITS as this module, and
// 10**DIGITS must exceed 2**BIT_SZ.
module bin2bcd_16
    import bin2bcd_16_pkg::*;
#(
    parameter int unsigned BIT_SZ = 16,
    parameter int unsigned DIGITS = DEFAULT_DIGITS
) (
    input  logic         clock,
    input  logic         nreset,
    bin2bcd_16_if.slave  bus
);

    localparam int unsigned BCD_BITS = BCD_W * DIGITS;
    localparam int unsigned CNT_W    = (BIT_SZ > 1) ? $clog2(BIT_SZ) : 1;

    state_t               state_q, state_d;
    logic [BIT_SZ-1:0]    bin_q, bin_d;
    logic [BCD_BITS-1:0]  scratch_q, scratch_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [BCD_BITS-1:0]  bcd_q, bcd_d;

    logic [BCD_BITS-1:0]  adj;
    logic [BCD_BITS-1:0]  shifted;
    logic                 last_shift;

    // Per-digit add-3, independent digits: no carry between them.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch_q[g*BCD_W +: BCD_W]),
            .dout (adj[g*BCD_W +: BCD_W])
        );
    end

    // The top bit of the corrected scratch is shifted out; it is always zero
    // when 10**DIGITS > 2**BIT_SZ.
    logic unused_adj_msb;
    assign unused_adj_msb = adj[BCD_BITS-1];

    assign shifted    = {adj[BCD_BITS-2:0], bin_q[BIT_SZ-1]};
    assign last_shift = (state_q == SHIFT) && (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bin_d     = bus.value;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(BIT_SZ - 1);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                bin_d     = {bin_q[BIT_SZ-2:0], 1'b0};
                cnt_d     = cnt_q - 1'b1;
                if (last_shift) begin
                    // Final shift result goes straight to bcd, never a partial value.
                    bcd_d   = shifted;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d, blank_next;
    logic              zero_above;

    // blank[i] set while digit i and every digit above it are zero; units never.
    always_comb begin
        blank_next = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above & (shifted[i*BCD_W +: BCD_W] == '0);
            blank_next[i] = zero_above;
        end
    end

    always_comb begin
        blank_d = blank_q;
        if (last_shift) begin
            blank_d = blank_next;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            blank_q <= blank_d;
        end
    end

    assign bus.blank = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_16.sv
// tb_bin2bcd_16: directed self-checking bench for bin2bcd_16.
// Inputs change and outputs are sampled 1 time unit after each posedge.
// Define BIN2BCD_BLANK_EN for both RTL and bench to also check blank.
module tb_bin2bcd_16;

    logic clock;
    logic nreset;

    int n_checks = 0;
    int n_fails  = 0;

    bin2bcd_16_if #(.BIT_SZ(16), .DIGITS(5)) bus ();

    bin2bcd_16 #(.BIT_SZ(16), .DIGITS(5)) dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advance until done is seen; at_edge is the edge index it rose on, -1 on timeout.
    task automatic wait_done(input int from_edge, output int at_edge);
        int e;
        e = from_edge;
        while (bus.done !== 1'b1 && e < from_edge + 60) begin
            tick();
            e++;
        end
        at_edge = (bus.done === 1'b1) ? e : -1;
    endtask

    task automatic check_blank(input string tag, input logic [4:0] exp);
`ifdef BIN2BCD_BLANK_EN
        check(tag, 32'(bus.blank), 32'(exp));
`endif
    endtask

    // One full conversion from IDLE with start held for a single cycle.
    task automatic convert(input string tag, input logic [15:0] v,
                           input logic [19:0] exp_bcd, input logic [4:0] exp_blank);
        int at;
        bus.value = v;
        bus.start = 1'b1;
        tick();                       // E0
        bus.start = 1'b0;
        check({tag, ".busy_e0"}, 32'(bus.busy), 32'd1);
        wait_done(0, at);
        check({tag, ".done_edge"}, 32'(at), 32'd16);
        check({tag, ".bcd"}, 32'(bus.bcd), 32'(exp_bcd));
        check({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
        check_blank({tag, ".blank"}, exp_blank);
        tick();
        check({tag, ".done_one_cycle"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int at;
        int at2;
        int ndone;
        int first;

        nreset    = 1'b0;
        bus.start = 1'b0;
        bus.value = '0;
        #12;
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.bcd", 32'(bus.bcd), 32'd0);
        check_blank("rst.blank", 5'b11110);
        tick();
        nreset = 1'b1;
        tick();

        convert("zero", 16'd0, 20'h00000, 5'b11110);
        convert("max", 16'd65535, 20'h65535, 5'b00000);

        // Second start at E5 must be ignored.
        bus.value = 16'd1234;
        bus.start = 1'b1;
        tick();                       // E0
        bus.start = 1'b0;
        repeat (4) tick();            // E4
        bus.value = 16'd9;
        bus.start = 1'b1;
        tick();                       // E5
        bus.start = 1'b0;
        bus.value = '0;
        check("ign.busy_e5", 32'(bus.busy), 32'd1);
        ndone = 0;
        first = -1;
        for (int e = 6; e <= 40; e++) begin
            tick();
            if (bus.done === 1'b1) begin
                ndone++;
                if (first < 0) first = e;
            end
        end
        check("ign.done_count", 32'(ndone), 32'd1);
        check("ign.done_edge", 32'(first), 32'd16);
        check("ign.bcd", 32'(bus.bcd), 32'h01234);
        check_blank("ign.blank", 5'b10000);

        // value changes during SHIFT must not affect the result.
        bus.value = 16'd42;
        bus.start = 1'b1;
        tick();                       // E0
        bus.start = 1'b0;
        repeat (2) tick();
        bus.value = 16'd1234;
        wait_done(2, at);
        check("hold.done_edge", 32'(at), 32'd16);
        check("hold.bcd", 32'(bus.bcd), 32'h00042);
        check_blank("hold.blank", 5'b11100);
        tick();

        // Reset mid-conversion aborts with no done.
        bus.value = 16'd500;
        bus.start = 1'b1;
        tick();                       // E0
        bus.start = 1'b0;
        repeat (7) tick();            // E7
        #4;
        nreset = 1'b0;
        #1;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.bcd", 32'(bus.bcd), 32'd0);
        check_blank("abort.blank", 5'b11110);
        ndone = 0;
        repeat (2) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        nreset = 1'b1;
        repeat (20) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        check("abort.no_done", 32'(ndone), 32'd0);
        check("abort.idle_busy", 32'(bus.busy), 32'd0);
        convert("after_abort", 16'd500, 20'h00500, 5'b11000);

        // Back-to-back with start held: results 17 cycles apart.
        bus.value = 16'd100;
        bus.start = 1'b1;
        tick();                       // E0
        bus.value = 16'd99;
        wait_done(0, at);
        check("b2b.first_edge", 32'(at), 32'd16);
        check("b2b.first_bcd", 32'(bus.bcd), 32'h00100);
        check_blank("b2b.first_blank", 5'b11000);
        tick();                       // E17, second start accepted
        check("b2b.done_low", 32'(bus.done), 32'd0);
        check("b2b.busy_again", 32'(bus.busy), 32'd1);
        wait_done(17, at2);
        bus.start = 1'b0;
        check("b2b.spacing", 32'(at2 - at), 32'd17);
        check("b2b.second_bcd", 32'(bus.bcd), 32'h00099);
        check_blank("b2b.second_blank", 5'b11100);
        repeat (3) tick();
        check("b2b.idle", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/bin2bcd_16.md
Name: bin2bcd_16

Overview:
- Sequential binary-to-BCD converter using double-dabble (shift-and-add-3), one bit per clock.
- Sits directly downstream of the 16-bit enable counter. It consumes the counter's count value and produces 5 packed BCD digits for the 7-segment display decoders.
- Uses a start/busy/done handshake so the display path can sample a stable count at its own rate.

Parameters:
- BIT_SZ, 16, binary input width.
- DIGITS, 5, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIT_SZ.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- nreset  input  1  asynchronous, active-low reset.
- start  input  1  request conversion of value; sampled on posedge.
- value  input  BIT_SZ  binary operand, typically the count output of the counter stage.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse: bcd has just been updated.
- bcd  output  4*DIGITS  packed BCD result. Digit 0 is bcd[3:0] (units); the highest digit is in the MSBs.

Behaviour:
- Reset (nreset=0, asynchronous): state=IDLE, busy=0, done=0, bcd=0. The internal shift register and bit counter are cleared.
- A reset asserted mid-conversion aborts it immediately. No done pulse is produced and bcd returns to 0.

State machine:
- IDLE:
  - If start=1 at a posedge: copy value into the binary shift register, clear the BCD scratch register, load bit counter=BIT_SZ-1, go to SHIFT, set busy=1.
  - Otherwise remain in IDLE.
- SHIFT, each posedge:
  - For every scratch digit >= 5, add 3 to that digit.
  - Then shift {scratch, binary} left by 1.
  - Decrement the bit counter.
  - On the posedge where the counter was 0 (the BIT_SZ-th shift): write the final scratch into bcd, pulse done=1, set busy=0, go to IDLE.

Latency:
- The start-sample edge is E0.
- bcd and done update at edge E(BIT_SZ), i.e. E16 by default.
- done is high for exactly one cycle.

Handshake rules:
- start while busy=1 is ignored. The in-flight conversion is not disturbed and no request is queued.
- value is captured only at the start-sample edge. Later changes to value have no effect on the result.
- Back-to-back: start=1 in the cycle where done=1 is accepted, since the FSM is already in IDLE. Sustained throughput is one result per BIT_SZ+1 cycles.
- bcd holds its last result until the next done. It is never partially updated.

Width rules:
- The scratch register is 4*DIGITS bits.
- Add-3 is applied to each digit independently; no carry propagates between digits.
- The result is always valid BCD: every digit is <= 9.

Optional Feature:
- Macro: BIN2BCD_BLANK_EN.
- Defined:
  - Adds output port blank[DIGITS-1:0], registered and updated on the same edge as bcd/done.
  - blank[i]=1 when digit i and all higher digits are 0, for i>=1.
  - blank[0] is always 0, so the units digit is never blanked.
  - Reset value: all ones except bit 0, i.e. 5'b11110.
- Undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package holds:
  - the FSM state typedef/encoding (IDLE, SHIFT);
  - the BCD digit width constant (4);
  - the add-3 threshold constant (5);
  - the default DIGITS value for the 16-bit configuration.
- Sub-module bcd_add3: combinational, 4-bit in, 4-bit out, adds 3 when the input is >= 5. It is instantiated DIGITS times in a generate loop.

Test Plan:
- Reset, then value=16'd0, start for 1 cycle -> busy high 16 cycles; done pulse at E16; bcd=20'h00000. With BLANK_EN, blank=5'b11110.
- value=16'd65535 -> bcd=20'h65535 at E16, done high exactly 1 cycle, busy=0 afterwards.
- value=16'd1234; at E5, start=1 again with value=16'd9 -> second start ignored; single done at E16; bcd=20'h01234. With BLANK_EN, blank=5'b10000.
- Drive value from the counter stage mid-count (e.g. 42), then change value during SHIFT -> bcd=20'h00042. With BLANK_EN, blank=5'b11100.
- Start a conversion of 16'd500, deassert nreset at E8 for 2 cycles -> bcd=0, busy=0, no done. After release, a new start with 16'd500 -> bcd=20'h00500 at E16.
- Back-to-back: start held high continuously with value=16'd100 then 16'd99 -> done pulses 17 cycles apart; bcd=20'h00100 then 20'h00099.
